// File: rtl/matmul_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply sequencer and loader.
package matmul_pkg;
    localparam int MM_DW      = 4;
    localparam int MM_MAX_DIM = 4;
    localparam int MM_DIM_W   = 4;
    localparam int MM_ADDR_W  = 4;
    localparam int MM_ACC_W   = 10;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ERR,
        ACC,
        OUT,
        DONE
    } state_t;
endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate: one product per enabled cycle, clear wins over enable.
// Result visible the cycle after the last enable; no backpressure of its own.
module mac_unit #(
    parameter int DW    = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DW-1:0]    a_i,
    input  logic [DW-1:0]    b_i,
    output logic [ACC_W-1:0] acc_o
);
    logic [2*DW-1:0]  prod;
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/matmul_sequencer.sv
// Walks i/j/k over loader operands, c1 ACC cycles per element then one OUT cycle minimum.
// Result held in OUT until res_ready; the loop stalls there, nothing is dropped.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DW      = MM_DW,
    parameter int MAX_DIM = MM_MAX_DIM,
    parameter int DIM_W   = MM_DIM_W,
    parameter int ADDR_W  = MM_ADDR_W,
    parameter int ACC_W   = MM_ACC_W
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [DIM_W-1:0]    r1,
    input  logic [DIM_W-1:0]    c1,
    input  logic [DIM_W-1:0]    r2,
    input  logic [DIM_W-1:0]    c2,
    output logic [ADDR_W-1:0]   a_addr,
    output logic [ADDR_W-1:0]   b_addr,
    input  logic [DW-1:0]       a_data,
    input  logic [DW-1:0]       b_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    output logic [ADDR_W/2-1:0] res_row,
    output logic [ADDR_W/2-1:0] res_col,
    output logic                busy,
    output logic                done,
    output logic                dim_err
);
    localparam int CW = ADDR_W / 2;

    state_t           state_q, state_d;
    logic [CW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DIM_W-1:0] r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
    logic             dim_err_q, dim_err_d;
    logic             acc_clr, acc_en;
    logic             dims_bad, k_last, j_last, i_last;
    logic [ACC_W-1:0] acc;

    mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .clr_i  (acc_clr),
        .en_i   (acc_en),
        .a_i    (a_data),
        .b_i    (b_data),
        .acc_o  (acc)
    );

    always_comb begin
        dims_bad = (c1_q != r2_q)
                || (r1_q == '0) || (c1_q == '0) || (r2_q == '0) || (c2_q == '0)
                || (r1_q > DIM_W'(MAX_DIM)) || (c1_q > DIM_W'(MAX_DIM))
                || (r2_q > DIM_W'(MAX_DIM)) || (c2_q > DIM_W'(MAX_DIM));
        k_last = (DIM_W'(k_q) == c1_q - DIM_W'(1));
        j_last = (DIM_W'(j_q) == c2_q - DIM_W'(1));
        i_last = (DIM_W'(i_q) == r1_q - DIM_W'(1));
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        r1_d      = r1_q;
        c1_d      = c1_q;
        r2_d      = r2_q;
        c2_d      = c2_q;
        dim_err_d = dim_err_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        a_addr    = '0;
        b_addr    = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    r1_d      = r1;
                    c1_d      = c1;
                    r2_d      = r2;
                    c2_d      = c2;
                    dim_err_d = 1'b0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (dims_bad) begin
                    state_d = ERR;
                end else begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_clr = 1'b1;
                    state_d = ACC;
                end
            end
            ERR: begin
                dim_err_d = 1'b1;
                state_d   = IDLE;
            end
            ACC: begin
                a_addr = ADDR_W'(i_q) * ADDR_W'(c1_q) + ADDR_W'(k_q);
                b_addr = ADDR_W'(k_q) * ADDR_W'(c2_q) + ADDR_W'(j_q);
                acc_en = 1'b1;
                if (k_last) begin
                    state_d = OUT;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            OUT: begin
                if (res_ready) begin
                    acc_clr = 1'b1;
                    k_d     = '0;
                    // Leave i/j at zero after the final element so nothing wraps.
                    if (i_last && j_last) begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = DONE;
                    end else begin
                        if (j_last) begin
                            j_d = '0;
                            i_d = i_q + CW'(1);
                        end else begin
                            j_d = j_q + CW'(1);
                        end
                        state_d = ACC;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            r1_q      <= '0;
            c1_q      <= '0;
            r2_q      <= '0;
            c2_q      <= '0;
            dim_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            r1_q      <= r1_d;
            c1_q      <= c1_d;
            r2_q      <= r2_d;
            c2_q      <= c2_d;
            dim_err_q <= dim_err_d;
        end
    end

    // The accumulator already holds the full sum throughout OUT and is frozen there.
    assign res_valid = (state_q == OUT);
    assign res_data  = (state_q == OUT) ? acc : '0;
    assign res_row   = i_q;
    assign res_col   = j_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dim_err   = dim_err_q | (state_q == ERR);
endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized bench for matmul_sequencer against a plain-arithmetic result model.
module tb_matmul_sequencer;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic [3:0] r1 = '0, c1 = '0, r2 = '0, c2 = '0;
    logic [3:0] a_addr, b_addr, a_data, b_data;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [9:0] res_data;
    logic [1:0] res_row, res_col;
    logic       busy, done, dim_err;

    logic [3:0] A_mem [16];
    logic [3:0] B_mem [16];

    typedef struct {
        int data;
        int row;
        int col;
    } res_t;
    res_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rmode    = 0;
    int bp_cnt   = 0;

    matmul_sequencer dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .r1        (r1),
        .c1        (c1),
        .r2        (r2),
        .c2        (c2),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_data    (a_data),
        .b_data    (b_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_row   (res_row),
        .res_col   (res_col),
        .busy      (busy),
        .done      (done),
        .dim_err   (dim_err)
    );

    always #5 CLK = ~CLK;

    assign a_data = A_mem[a_addr];
    assign b_data = B_mem[b_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int model_elem(input int i, input int j, input int c1v, input int c2v);
        int s = 0;
        for (int k = 0; k < c1v; k++) s += int'(A_mem[i*c1v+k]) * int'(B_mem[k*c2v+j]);
        return s;
    endfunction

    task automatic build_expected(input int r1v, input int c1v, input int c2v);
        res_t r;
        exp_q.delete();
        for (int i = 0; i < r1v; i++) begin
            for (int j = 0; j < c2v; j++) begin
                r.data = model_elem(i, j, c1v, c2v);
                r.row  = i;
                r.col  = j;
                exp_q.push_back(r);
            end
        end
    endtask

    // Result scoreboard: every valid cycle must show the head element, popped on handshake.
    always @(negedge CLK) begin
        if (RST_N && res_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", res_valid, 0);
            end else begin
                check("res_data", res_data, exp_q[0].data);
                check("res_row", res_row, exp_q[0].row);
                check("res_col", res_col, exp_q[0].col);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Consumer: 0 = always ready, 1 = five stall cycles per element, 2 = random.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rmode)
                1: begin
                    if (!res_valid) begin
                        bp_cnt    = 0;
                        res_ready = 1'b0;
                    end else if (bp_cnt < 5) begin
                        bp_cnt++;
                        res_ready = 1'b0;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                2:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b1;
            endcase
        end
    end

    task automatic start_run(input int r1v, input int c1v, input int r2v, input int c2v);
        @(posedge CLK);
        #1;
        r1 = 4'(r1v); c1 = 4'(c1v); r2 = 4'(r2v); c2 = 4'(c2v);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic run_ok(input int r1v, input int c1v, input int c2v, input int mode, output int lat);
        int cnt = 1;
        rmode = mode;
        build_expected(r1v, c1v, c2v);
        start_run(r1v, c1v, c1v, c2v);
        check("dim_err_cleared", dim_err, 0);
        check("busy_at_check", busy, 1);
        while (!done && cnt < 1000) begin
            if (mode == 0) begin
                int ea = 0;
                int eb = 0;
                if (cnt >= 2) begin
                    int p = (cnt - 2) % (c1v + 1);
                    int e = (cnt - 2) / (c1v + 1);
                    if (p < c1v) begin
                        ea = (e / c2v) * c1v + p;
                        eb = p * c2v + (e % c2v);
                    end
                end
                check("addr", {a_addr, b_addr}, ea * 16 + eb);
            end
            @(posedge CLK);
            #1;
            cnt++;
        end
        lat = cnt;
        if (!done) check("done_timeout", done, 1);
        if (mode == 0) check("latency", cnt, 2 + r1v * c2v * (c1v + 1));
        check("results_outstanding", exp_q.size(), 0);
        check("dim_err_ok_run", dim_err, 0);
        @(posedge CLK);
        #1;
        check("done_pulse", {done, busy}, 0);
    endtask

    task automatic run_err(input int r1v, input int c1v, input int r2v, input int c2v);
        rmode = 0;
        exp_q.delete();
        start_run(r1v, c1v, r2v, c2v);
        check("dim_err_at_check", dim_err, 0);
        @(posedge CLK);
        #1;
        check("dim_err_flag", dim_err, 1);
        for (int n = 0; n < 4; n++) begin
            @(posedge CLK);
            #1;
            check("err_no_output", {res_valid, done}, 0);
        end
        check("err_sticky_idle", {dim_err, busy}, 2'b10);
    endtask

    task automatic fill_random();
        for (int n = 0; n < 16; n++) begin
            A_mem[n] = 4'($urandom_range(0, 15));
            B_mem[n] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        int lat;
        fill_random();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs",
              {res_valid, busy, done, dim_err, a_addr, b_addr, res_data, res_row, res_col}, 0);
        RST_N = 1'b1;

        // 2x2 worked example, model pinned to literals first.
        A_mem[0] = 1; A_mem[1] = 15; A_mem[2] = 2; A_mem[3] = 2;
        B_mem[0] = 1; B_mem[1] = 9;  B_mem[2] = 2; B_mem[3] = 2;
        check("model_2x2_00", model_elem(0, 0, 2, 2), 31);
        check("model_2x2_01", model_elem(0, 1, 2, 2), 39);
        check("model_2x2_10", model_elem(1, 0, 2, 2), 6);
        check("model_2x2_11", model_elem(1, 1, 2, 2), 22);
        run_ok(2, 2, 2, 0, lat);
        check("latency_2x2", lat, 14);
        run_ok(2, 2, 2, 1, lat);

        // 1x3 by 3x2.
        A_mem[0] = 1; A_mem[1] = 2; A_mem[2] = 3;
        B_mem[0] = 1; B_mem[1] = 0; B_mem[2] = 0; B_mem[3] = 1; B_mem[4] = 1; B_mem[5] = 1;
        check("model_1x3_00", model_elem(0, 0, 3, 2), 4);
        check("model_1x3_01", model_elem(0, 1, 3, 2), 5);
        run_ok(1, 3, 2, 0, lat);

        // Dimension errors, then a valid start clears the flag.
        run_err(2, 2, 8, 2);
        run_err(0, 2, 2, 2);
        run_err(2, 5, 5, 2);
        run_ok(1, 3, 2, 0, lat);

        // 4x4 of all 15s reaches the accumulator maximum.
        for (int n = 0; n < 16; n++) begin
            A_mem[n] = 4'd15;
            B_mem[n] = 4'd15;
        end
        check("model_4x4_max", model_elem(3, 3, 4, 4), 900);
        run_ok(4, 4, 4, 0, lat);
        run_ok(4, 4, 4, 2, lat);

        // Reset during ACC of element (1,0), then a clean rerun.
        A_mem[0] = 1; A_mem[1] = 15; A_mem[2] = 2; A_mem[3] = 2;
        B_mem[0] = 1; B_mem[1] = 9;  B_mem[2] = 2; B_mem[3] = 2;
        rmode = 0;
        build_expected(2, 2, 2);
        start_run(2, 2, 2, 2);
        repeat (7) begin
            @(posedge CLK);
            #1;
        end
        check("mid_addr_elem10", {a_addr, b_addr, res_row, res_col}, {4'd2, 4'd0, 2'd1, 2'd0});
        check("mid_delivered", exp_q.size(), 2);
        RST_N = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(posedge CLK);
            #1;
            check("mid_reset_outputs",
                  {res_valid, busy, done, dim_err, a_addr, b_addr, res_data, res_row, res_col}, 0);
        end
        exp_q.delete();
        RST_N = 1'b1;
        run_ok(2, 2, 2, 0, lat);
        check("latency_after_reset", lat, 14);

        // Randomized runs, with occasional incompatible dimensions.
        for (int t = 0; t < 25; t++) begin
            int rv = $urandom_range(1, 4);
            int cv = $urandom_range(1, 4);
            int qv = $urandom_range(1, 4);
            fill_random();
            if ($urandom_range(0, 5) == 0) begin
                run_err(rv, cv, (cv % 4) + 1, qv);
            end else begin
                run_ok(rv, cv, qv, $urandom_range(0, 2), lat);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Controller that sequences a matrix multiply over the operand matrices held by the matrix loader. It takes the captured dimensions R1, C1, R2, C2 and a start pulse, and checks that the dimensions are compatible. It then walks the i/j/k loop, driving read addresses into the loader's matrix_1/matrix_2 arrays and accumulating products. Each result element is emitted on a valid/ready handshake toward the result store or output shifter.

Parameters:
DW, 4, operand element width (matches loader data_send width)
MAX_DIM, 4, largest legal row/column count
DIM_W, 4, width of dimension inputs
ADDR_W, 4, operand address width, $clog2(MAX_DIM*MAX_DIM)
ACC_W, 10, accumulator width, 2*DW + $clog2(MAX_DIM)

Ports:
CLK  in  1  clock, all logic on rising edge
RST_N  in  1  synchronous active-low reset
start  in  1  single-cycle request to begin a multiply
r1, c1, r2, c2  in  DIM_W each  dimensions from loader, sampled on accepted start
a_addr  out  ADDR_W  matrix_1 read index, row-major i*c1+k
b_addr  out  ADDR_W  matrix_2 read index, row-major k*c2+j
a_data, b_data  in  DW each  operand values, combinational read of a_addr/b_addr in same cycle
res_valid  out  1  result element available
res_ready  in  1  consumer accepts result
res_data  out  ACC_W  result element value, unsigned
res_row, res_col  out  ADDR_W/2 each  result coordinates i, j
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last element accepted
dim_err  out  1  sticky dimension error flag

Behaviour:
- Reset (RST_N low at a CLK edge): state=IDLE; i/j/k=0; acc=0; all outputs 0. Reset applies mid-operation, and any in-flight result is discarded.
- IDLE: if start=1, latch r1, c1, r2, c2, clear dim_err, go to CHECK. start in any other state is ignored.
- CHECK (1 cycle): go to ERR if any of the following holds; otherwise set i=j=k=0, acc=0, go to ACC.
  - c1 != r2;
  - any dimension is 0;
  - any dimension > MAX_DIM.
- ERR (1 cycle): set dim_err=1 and return to IDLE. dim_err stays high until the next accepted start.
- ACC: product = a_data*b_data, unsigned and full-width.
  - If k < c1-1: acc += product, k++.
  - If k == c1-1: res_data <= acc+product, go to OUT.
  - Each element takes exactly c1 ACC cycles. Addresses are valid only in ACC and are 0 elsewhere.
- OUT: res_valid=1, with res_data/res_row/res_col held stable until res_ready.
  - On res_valid & res_ready: acc=0, k=0.
  - If j < c2-1: j++. Else j=0 and i++.
  - If i==r1-1 and j==c2-1, go to DONE; otherwise go to ACC.
- DONE: done=1 for one cycle, then IDLE.
- Latency with res_ready held high: 1 (CHECK) + r1*c2*(c1+1) + 1 (DONE) cycles from start to done.
- Overflow is impossible: the maximum value 4*15*15=900 fits ACC_W=10.
- Counters never wrap, because the dimensions are bounded by CHECK.

Decomposition:
- Package matmul_pkg: state enum {IDLE, CHECK, ERR, ACC, OUT, DONE}, plus the DW/MAX_DIM/ACC_W constants shared with the loader.
- Sub-module mac_unit: holds the registered accumulator with clear and enable inputs and ACC_W output. The sequencer owns only the FSM, counters and address generation.

Test Plan:
- 2x2 multiply: A=[1,15;2,2], B=[1,9;2,2], res_ready=1 -> results in order (0,0)=31, (0,1)=39, (1,0)=6, (1,1)=22. done rises 1+4*3+1=14 cycles after start.
- 1x3 by 3x2: A=[1,2,3], B=[1,0;0,1;1,1] -> results (0,0)=4, (0,1)=5. a_addr sequence 0,1,2 per element; b_addr sequence 0,2,4 then 1,3,5.
- Mismatch r1=2, c1=2, r2=8, c2=2 -> dim_err=1 two cycles after start, no res_valid, done stays 0. A following valid start clears dim_err.
- Backpressure on the 2x2 case, res_ready low for 5 cycles at each element -> res_data/row/col held stable, no element lost or duplicated, same 4 values in order.
- 4x4 all-15 operands -> all 16 results = 900, no overflow.
- RST_N low during ACC of element (1,0), then a new start -> all outputs 0 during reset, and the fresh run produces the full correct result set from (0,0).
